// File: rtl/spi_burst_arbiter.sv
// Round-robin arbiter sharing one word-level SPI controller between NUM_REQ requesters.
// Each grant runs a whole burst under that requester's chip select, word by word.
module spi_burst_arbiter #(
  parameter int NUM_REQ  = 2,
  parameter int WORD_W   = 8,
  parameter int LEN_W    = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ-1:0][LEN_W-1:0]   req_len,
  input  logic [NUM_REQ-1:0][WORD_W-1:0]  req_wdata,
  input  logic [NUM_REQ-1:0]              req_wvalid,
  output logic [NUM_REQ-1:0]              req_wready,
  output logic [WORD_W-1:0]               rsp_rdata,
  output logic [NUM_REQ-1:0]              rsp_rvalid,
  output logic [NUM_REQ-1:0]              done,
  output logic [NUM_REQ-1:0]              grant,
  output logic                            busy,
  output logic [NUM_REQ-1:0]              cs_n,
  output logic                            spi_start,
  output logic [WORD_W-1:0]               spi_wdata,
  input  logic [WORD_W-1:0]               spi_rdata,
  input  logic                            spi_rvalid,
  input  logic                            spi_busy
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TMAX  = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int TMR_W = $clog2(TMAX + 2);
  localparam logic [TMR_W-1:0] SETUP_LAST = TMR_W'((CS_SETUP > 0) ? CS_SETUP - 1 : 0);
  localparam logic [TMR_W-1:0] HOLD_LAST  = TMR_W'((CS_HOLD  > 0) ? CS_HOLD  - 1 : 0);

  typedef enum logic [2:0] {IDLE, SETUP, FETCH, START, WAIT, HOLD} state_t;

  state_t             state, state_nx;
  logic [IDX_W-1:0]   owner, rr_ptr, pick;
  logic               pick_vld;
  logic [LEN_W-1:0]   wcnt;
  logic [TMR_W-1:0]   tmr;
  logic               got_rx;
  logic               wait_fin;

  function automatic logic [NUM_REQ-1:0] oh(input logic [IDX_W-1:0] i);
    oh = '0;
    oh[i] = 1'b1;
  endfunction

  // first pending requester at or after the round-robin pointer
  always_comb begin
    int j;
    logic [IDX_W-1:0] jj;
    pick = '0;
    pick_vld = 1'b0;
    j = 0;
    jj = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      j = int'(rr_ptr) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      jj = IDX_W'(j);
      if (req[jj]) begin
        pick = jj;
        pick_vld = 1'b1;
      end
    end
  end

  // a word is finished once its data came back and the controller has gone idle again
  assign wait_fin  = (got_rx || spi_rvalid) && !spi_busy;
  assign spi_start = (state == START) && !spi_busy;
  assign busy      = (state != IDLE);

  always_comb begin
    req_wready = '0;
    if (state == FETCH && req_wvalid[owner]) req_wready = oh(owner);
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (pick_vld && done == '0) state_nx = SETUP;
      SETUP: if (tmr == SETUP_LAST) state_nx = FETCH;
      FETCH: if (req_wvalid[owner]) state_nx = START;
      START: if (!spi_busy) state_nx = WAIT;
      WAIT:  if (wait_fin) state_nx = (wcnt == '0) ? HOLD : FETCH;
      HOLD:  if (tmr == HOLD_LAST) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= '0;
      rr_ptr     <= '0;
      grant      <= '0;
      cs_n       <= '1;
      wcnt       <= '0;
      tmr        <= '0;
      got_rx     <= 1'b0;
      spi_wdata  <= '0;
      rsp_rdata  <= '0;
      rsp_rvalid <= '0;
      done       <= '0;
    end else begin
      state      <= state_nx;
      rsp_rvalid <= '0;
      done       <= '0;
      case (state)
        IDLE: if (pick_vld && done == '0) begin
          owner <= pick;
          grant <= oh(pick);
          cs_n  <= ~oh(pick);
          wcnt  <= req_len[pick];
          tmr   <= '0;
        end
        SETUP: tmr <= (tmr == SETUP_LAST) ? '0 : tmr + 1'b1;
        FETCH: if (req_wvalid[owner]) spi_wdata <= req_wdata[owner];
        WAIT: begin
          if (spi_rvalid) begin
            rsp_rdata  <= spi_rdata;
            rsp_rvalid <= oh(owner);
            got_rx     <= 1'b1;
          end
          if (wait_fin) begin
            got_rx <= 1'b0;
            if (wcnt != '0) wcnt <= wcnt - 1'b1;
          end
        end
        HOLD: begin
          tmr <= tmr + 1'b1;
          if (tmr == HOLD_LAST) begin
            cs_n   <= '1;
            done   <= oh(owner);
            grant  <= '0;
            rr_ptr <= (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_burst_arbiter.sv
// Randomized bench for spi_burst_arbiter: requester drivers, a controller model with random
// latency, and a round-robin burst reference model predicting starts, responses and done order.
module tb_spi_burst_arbiter;
  localparam int N = 2, W = 8, L = 4;

  logic clk = 1'b0, rst_n = 1'b1;
  logic [N-1:0] req = '0, req_wvalid = '0;
  logic [N-1:0] req_wready, rsp_rvalid, done, grant, cs_n;
  logic [N-1:0][L-1:0] req_len = '0;
  logic [N-1:0][W-1:0] req_wdata = '0;
  logic [W-1:0] rsp_rdata, spi_wdata, spi_rdata = '0;
  logic busy, spi_start, spi_rvalid = 1'b0, spi_busy = 1'b0;

  spi_burst_arbiter #(.NUM_REQ(N), .WORD_W(W), .LEN_W(L), .CS_SETUP(2), .CS_HOLD(2)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_len(req_len), .req_wdata(req_wdata),
    .req_wvalid(req_wvalid), .req_wready(req_wready), .rsp_rdata(rsp_rdata),
    .rsp_rvalid(rsp_rvalid), .done(done), .grant(grant), .busy(busy), .cs_n(cs_n),
    .spi_start(spi_start), .spi_wdata(spi_wdata), .spi_rdata(spi_rdata),
    .spi_rvalid(spi_rvalid), .spi_busy(spi_busy));

  always #5 clk = ~clk;

  int cmp = 0, nfail = 0, cyc = 0, viol = 0, cs_err = 0;
  int nb[2] = '{0, 0};
  int lens[2] = '{0, 0};
  int mp = 0;
  logic [1:0] wen = 2'b11;
  logic [7:0] wq0[$], wq1[$];
  logic [7:0] st_q[$], e_st[$];
  int rs_q[$], dn_q[$], gr_q[$], e_rs[$], e_dn[$];
  logic [N-1:0] wr_seen = '0, done_seen = '0, prev_grant = '0, prev_cs = '1;
  logic start_seen = 1'b0;
  int t_cs = 0, setup_lat = -1;
  bit first_pend = 0;
  int s_lat = -1, s_tail = 0;
  bit s_act = 0;
  logic [7:0] tmp;

  // monitors sample mid-cycle
  always @(negedge clk) begin
    cyc++;
    wr_seen = req_wready; done_seen = done; start_seen = spi_start;
    if (spi_start) begin
      st_q.push_back(spi_wdata);
      if (spi_busy) viol++;
      if (first_pend) begin setup_lat = cyc - t_cs; first_pend = 0; end
    end
    if (rsp_rvalid != '0) begin
      rs_q.push_back((rsp_rvalid[1] ? 256 : 0) + int'(rsp_rdata));
      if ($countones(rsp_rvalid) != 1) cs_err++;
    end
    if (done != '0) dn_q.push_back(done[1] ? 1 : 0);
    if (grant != '0 && prev_grant == '0) gr_q.push_back(grant[1] ? 1 : 0);
    if (&prev_cs && !(&cs_n)) begin t_cs = cyc; first_pend = 1; end
    if (cs_n == 2'b00) cs_err++;
    if (rst_n && cs_n != ~grant) cs_err++;
    if (rst_n && !busy && cs_n != 2'b11) cs_err++;
    prev_grant = grant; prev_cs = cs_n;
  end

  // requester drivers and SPI controller model; inputs change just after the edge
  always @(posedge clk) begin
    #1;
    if (wr_seen[0] && wq0.size() > 0) tmp = wq0.pop_front();
    if (wr_seen[1] && wq1.size() > 0) tmp = wq1.pop_front();
    for (int r = 0; r < 2; r++) if (done_seen[r] && nb[r] > 0) nb[r]--;
    req[0] = nb[0] > 0;
    req[1] = nb[1] > 0;
    req_len[0] = L'(lens[0]);
    req_len[1] = L'(lens[1]);
    req_wvalid[0] = wen[0] && wq0.size() > 0;
    req_wvalid[1] = wen[1] && wq1.size() > 0;
    req_wdata[0] = (wq0.size() > 0) ? wq0[0] : 8'h00;
    req_wdata[1] = (wq1.size() > 0) ? wq1[0] : 8'h00;
    spi_rvalid = 1'b0;
    if (!rst_n) begin
      spi_busy = 1'b0; s_act = 0;
    end else if (start_seen) begin
      spi_busy = 1'b1; s_act = 1; spi_rdata = spi_wdata;
      s_lat = $urandom_range(1, 5); s_tail = $urandom_range(0, 3);
    end else if (s_act) begin
      if (s_lat > 0) s_lat--;
      else if (s_lat == 0) begin spi_rvalid = 1'b1; s_lat = -1; end
      else if (s_tail > 0) s_tail--;
      else begin spi_busy = 1'b0; s_act = 0; end
    end
  end

  // reference: strict round robin over pending burst counts, each burst moves len+1 words
  task automatic build_model(input int n0, input int n1);
    int c[2];
    int p, r;
    logic [7:0] q0[$], q1[$];
    logic [7:0] w;
    c[0] = n0; c[1] = n1; p = mp; r = 0;
    q0 = wq0; q1 = wq1;
    e_st.delete(); e_rs.delete(); e_dn.delete();
    while (c[0] + c[1] > 0) begin
      for (int i = 0; i < 2; i++) if (c[(p + i) % 2] > 0) begin r = (p + i) % 2; break; end
      c[r]--;
      e_dn.push_back(r);
      p = (r + 1) % 2;
      for (int k = 0; k <= lens[r]; k++) begin
        w = (r == 1) ? q1.pop_front() : q0.pop_front();
        e_st.push_back(w);
        e_rs.push_back(r * 256 + int'(w));
      end
    end
    mp = p;
  endtask

  task automatic launch(input int n0, input int n1);
    build_model(n0, n1);
    st_q.delete(); rs_q.delete(); dn_q.delete(); gr_q.delete();
    @(posedge clk); #1;
    nb[0] = n0; nb[1] = n1;
  endtask

  task automatic wait_done(input int n, output bit to);
    to = 1;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (dn_q.size() >= n) begin to = 0; break; end
    end
    repeat (4) @(negedge clk);
  endtask

  function automatic int sb_diff();
    int d = 0;
    if (st_q.size() != e_st.size()) d++; else foreach (st_q[i]) if (st_q[i] !== e_st[i]) d++;
    if (rs_q.size() != e_rs.size()) d++; else foreach (rs_q[i]) if (rs_q[i] != e_rs[i]) d++;
    if (dn_q.size() != e_dn.size()) d++; else foreach (dn_q[i]) if (dn_q[i] != e_dn[i]) d++;
    if (gr_q.size() != e_dn.size()) d++; else foreach (gr_q[i]) if (gr_q[i] != e_dn[i]) d++;
    return d;
  endfunction

  task automatic test_reset();
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    cmp++;
    if ({grant, cs_n, busy, spi_start, done, rsp_rvalid, req_wready} !== 12'b00_11_0_0_00_00_00) begin
      nfail++; $display("FAIL reset_ctrl: got %b want 001100000000",
        {grant, cs_n, busy, spi_start, done, rsp_rvalid, req_wready});
    end
    cmp++;
    if ({spi_wdata, rsp_rdata} !== 16'h0000) begin
      nfail++; $display("FAIL reset_data: got %h want 0000", {spi_wdata, rsp_rdata});
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    cmp++;
    if ({busy, grant, cs_n} !== 5'b0_00_11) begin
      nfail++; $display("FAIL idle_after_reset: got %b want 00011", {busy, grant, cs_n});
    end
  endtask

  task automatic test_single();
    bit to;
    lens[0] = 0; wq0.push_back(8'hA5);
    launch(1, 0);
    wait_done(1, to);
    cmp++;
    if (to !== 0) begin nfail++; $display("FAIL single_timeout: done not seen"); end
    cmp++;
    if (st_q.size() != 1 || st_q[0] !== 8'hA5) begin
      nfail++; $display("FAIL single_start: %0d starts first %h want 1 x a5", st_q.size(), st_q[0]);
    end
    cmp++;
    if (rs_q.size() != 1 || rs_q[0] != 'hA5 || dn_q.size() != 1 || dn_q[0] != 0) begin
      nfail++; $display("FAIL single_rsp: rsp %0d done %0d want a5 owner0 and one done0", rs_q[0], dn_q.size());
    end
    cmp++;
    if (setup_lat != 3) begin nfail++; $display("FAIL setup_latency: got %0d want 3", setup_lat); end
  endtask

  task automatic test_burst4();
    bit to;
    lens[0] = 3;
    for (int i = 1; i <= 4; i++) wq0.push_back(8'(i));
    launch(1, 0);
    wait_done(1, to);
    cmp++;
    if (to !== 0 || st_q.size() != 4 || rs_q.size() != 4) begin
      nfail++; $display("FAIL burst4_counts: starts %0d rsp %0d want 4 4", st_q.size(), rs_q.size());
    end
    cmp++;
    if (sb_diff() != 0) begin nfail++; $display("FAIL burst4_model: %0d diffs want 0", sb_diff()); end
    cmp++;
    if (cs_err != 0) begin nfail++; $display("FAIL burst4_cs: %0d cs faults want 0", cs_err); end
  endtask

  task automatic test_stall();
    bit to;
    int n, bad;
    lens[0] = 2;
    repeat (3) wq0.push_back(8'($urandom));
    launch(1, 0);
    for (int i = 0; i < 200 && st_q.size() < 1; i++) @(negedge clk);
    @(posedge clk); #1 wen[0] = 1'b0;
    n = st_q.size(); bad = 0;
    repeat (50) begin @(negedge clk); if (cs_n[0] !== 1'b0) bad++; end
    cmp++;
    if (n != 1 || st_q.size() != n) begin
      nfail++; $display("FAIL stall_start: starts %0d during stall after %0d want 1", st_q.size(), n);
    end
    cmp++;
    if (bad != 0) begin nfail++; $display("FAIL stall_cs: cs_n[0] high %0d cycles want 0", bad); end
    @(posedge clk); #1 wen[0] = 1'b1;
    wait_done(1, to);
    cmp++;
    if (to !== 0 || sb_diff() != 0) begin nfail++; $display("FAIL stall_resume: to %0d diffs %0d want 0 0", to, sb_diff()); end
  endtask

  task automatic test_reset_mid();
    lens[0] = 3;
    repeat (4) wq0.push_back(8'($urandom));
    launch(1, 0);
    for (int i = 0; i < 300 && st_q.size() < 2; i++) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    cmp++;
    if ({cs_n, busy, grant} !== 5'b11_0_00) begin
      nfail++; $display("FAIL reset_mid_async: got %b want 11000", {cs_n, busy, grant});
    end
    nb[0] = 0; nb[1] = 0; wq0.delete(); wq1.delete(); mp = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    cmp++;
    if (dn_q.size() != 0 || cs_n !== 2'b11) begin
      nfail++; $display("FAIL reset_mid_done: %0d done pulses cs_n %b want 0 11", dn_q.size(), cs_n);
    end
  endtask

  task automatic test_round_robin();
    bit to;
    lens[0] = $urandom_range(0, 3); lens[1] = $urandom_range(0, 3);
    repeat (2 * (lens[0] + 1)) wq0.push_back(8'($urandom));
    repeat (lens[1] + 1) wq1.push_back(8'($urandom));
    launch(2, 1);
    wait_done(3, to);
    cmp++;
    if (to !== 0 || gr_q.size() != 3 || gr_q[0] != 0 || gr_q[1] != 1 || gr_q[2] != 0) begin
      nfail++; $display("FAIL rr_order: %0d grants first %0d %0d %0d want 0 1 0", gr_q.size(), gr_q[0], gr_q[1], gr_q[2]);
    end
    cmp++;
    if (sb_diff() != 0) begin nfail++; $display("FAIL rr_model: %0d diffs want 0", sb_diff()); end
  endtask

  task automatic test_maxlen();
    bit to;
    lens[1] = 15;
    repeat (16) wq1.push_back(8'($urandom));
    launch(0, 1);
    wait_done(1, to);
    cmp++;
    if (to !== 0 || st_q.size() != 16 || dn_q.size() != 1) begin
      nfail++; $display("FAIL maxlen: starts %0d done %0d want 16 1", st_q.size(), dn_q.size());
    end
    cmp++;
    if (sb_diff() != 0) begin nfail++; $display("FAIL maxlen_model: %0d diffs want 0", sb_diff()); end
  endtask

  task automatic test_random();
    bit to;
    int n0, n1;
    for (int k = 0; k < 6; k++) begin
      n0 = $urandom_range(0, 2); n1 = $urandom_range(0, 2);
      if (n0 + n1 == 0) n0 = 1;
      lens[0] = $urandom_range(0, 5); lens[1] = $urandom_range(0, 5);
      repeat (n0 * (lens[0] + 1)) wq0.push_back(8'($urandom));
      repeat (n1 * (lens[1] + 1)) wq1.push_back(8'($urandom));
      launch(n0, n1);
      wait_done(n0 + n1, to);
      cmp++;
      if (to !== 0 || sb_diff() != 0) begin
        nfail++; $display("FAIL random_round%0d: to %0d diffs %0d want 0 0", k, to, sb_diff());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst4();
    test_stall();
    test_reset_mid();
    test_round_robin();
    test_maxlen();
    test_random();
    cmp++;
    if (viol != 0) begin nfail++; $display("FAIL start_while_busy: %0d events want 0", viol); end
    cmp++;
    if (cs_err != 0) begin nfail++; $display("FAIL cs_integrity: %0d faults want 0", cs_err); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, nfail);
    $finish;
  end
endmodule
